// File: rtl/cpu_req_issuer.sv
// Request issuer: buffers CPU requests in a small FIFO and issues them one at a time
// to the MMU, waiting for the handshake/completion or aborting after a timeout.
module cpu_req_issuer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  input  logic                      instr_write,
  input  logic [ADDR_W-1:0]         instr_address,
  input  logic [DATA_W-1:0]         instr_wdata_in,
  output logic                      instr_ready,
  output logic                      valid_instr,
  output logic                      CPU_write,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         write_data_out,
  input  logic                      MMU_ready,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_return_data,
  output logic                      proc_done,
  output logic [DATA_W-1:0]         proc_return_data,
  output logic                      timeout_err,
  output logic [$clog2(DEPTH):0]    queue_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t              state;
  logic                accepted;
  logic [WCNT_W-1:0]   wait_cnt;

  logic                q_write [DEPTH];
  logic [ADDR_W-1:0]   q_addr  [DEPTH];
  logic [DATA_W-1:0]   q_data  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  logic push;
  logic pop;
  logic complete;
  logic expire;

  assign instr_ready = (queue_count < FULL_CNT);
  assign push        = instr_valid && instr_ready;
  // Completion wins over timeout when both would fire on the same edge.
  assign complete    = (state == WAIT) && accepted && MMU_ready && mem_ready;
  assign expire      = (state == WAIT) && !complete && (wait_cnt == WAIT_LAST);
  assign pop         = complete || expire;

  always_ff @(posedge clk) begin
    if (push) begin
      q_write[wr_ptr] <= instr_write;
      q_addr[wr_ptr]  <= instr_address;
      q_data[wr_ptr]  <= instr_wdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  // The head entry stays queued while in flight; it is popped only on completion or abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      valid_instr      <= 1'b0;
      CPU_write        <= 1'b0;
      address          <= '0;
      write_data_out   <= '0;
      proc_done        <= 1'b0;
      timeout_err      <= 1'b0;
      proc_return_data <= '0;
      accepted         <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      valid_instr <= 1'b0;
      proc_done   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (queue_count != '0 && MMU_ready) begin
            state          <= SEND;
            valid_instr    <= 1'b1;
            CPU_write      <= q_write[rd_ptr];
            address        <= q_addr[rd_ptr];
            write_data_out <= q_data[rd_ptr];
            accepted       <= 1'b0;
          end
        end
        SEND: begin
          state    <= WAIT;
          wait_cnt <= '0;
          if (!MMU_ready) accepted <= 1'b1;
        end
        WAIT: begin
          if (complete) begin
            proc_done <= 1'b1;
            if (!CPU_write) proc_return_data <= mem_return_data;
            state <= IDLE;
          end else if (expire) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (!MMU_ready) accepted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
